// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared CORE-V-X interface types.
// x_wb_entry_t holds one queued coprocessor result waiting for the EX-stage write port.
package cv32e40p_core_v_xif_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
   } x_wb_entry_t;

endpackage

// File: rtl/cv32e40p_x_wb_fifo.sv
// Small circular FIFO of x_wb_entry_t used to park coprocessor results.
// Pushes while full and pops while empty are ignored.
module cv32e40p_x_wb_fifo
   import cv32e40p_core_v_xif_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  x_wb_entry_t      data_i,
   output x_wb_entry_t      data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   x_wb_entry_t      mem_q [DEPTH];
   x_wb_entry_t      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cv32e40p_x_wb_arbiter.sv
// EX-stage write-port arbiter between core writebacks and CORE-V-X results.
// Queued X results may lose to the core at most MAX_WAIT times before stalling EX.
module cv32e40p_x_wb_arbiter
   import cv32e40p_core_v_xif_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        x_result_valid_i,
   output logic        x_result_ready_o,
   input  logic [3:0]  x_result_id_i,
   input  logic [4:0]  x_result_rd_i,
   input  logic        x_result_we_i,
   input  logic [31:0] x_result_data_i,
   input  logic        ex_we_i,
   input  logic [5:0]  ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   output logic        rf_we_o,
   output logic [5:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        ex_stall_o,
   output logic        x_wb_done_o,
   output logic [3:0]  x_wb_id_o,
   output logic        x_pending_o
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);

   x_wb_entry_t       head, incoming, cand;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              fire, writeable, cand_valid, x_wins, bypass_wr;
   logic              push, pop;
   logic [WAIT_W-1:0] wait_q, wait_d;

   assign incoming = '{id: x_result_id_i, rd: x_result_rd_i, data: x_result_data_i};

   assign x_result_ready_o = ~fifo_full;
   assign x_pending_o      = (fifo_count != '0);

   assign fire      = x_result_valid_i & x_result_ready_o;
   assign writeable = x_result_we_i & (x_result_rd_i != 5'd0);

   // The FIFO head always has precedence so X results retire in acceptance order.
   assign cand_valid = ~fifo_empty | (fire & writeable);
   assign cand       = fifo_empty ? incoming : head;

   // wait_q never exceeds MAX_WAIT, so equality is the starvation trigger.
   assign x_wins    = cand_valid & (~ex_we_i | (wait_q == MAX_WAIT_W));
   assign bypass_wr = x_wins & fifo_empty;
   assign pop       = x_wins & ~fifo_empty;
   assign push      = fire & writeable & ~bypass_wr;

   always_comb begin
      wait_d = '0;
      if (cand_valid && !x_wins) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_comb begin
      rf_we_o     = ex_we_i;
      rf_waddr_o  = ex_waddr_i;
      rf_wdata_o  = ex_wdata_i;
      ex_stall_o  = 1'b0;
      x_wb_done_o = 1'b0;
      x_wb_id_o   = '0;
      if (x_wins) begin
         rf_we_o     = 1'b1;
         rf_waddr_o  = {1'b0, cand.rd};
         rf_wdata_o  = cand.data;
         ex_stall_o  = ex_we_i;
         x_wb_done_o = 1'b1;
         x_wb_id_o   = cand.id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   cv32e40p_x_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (incoming),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule
